// File: rtl/id_wb_arb.sv
// Write-port arbiter for the decode-stage register file: the pipeline writeback has
// priority, and multi-cycle results queue in a 2-entry FIFO behind a starvation limit.
module id_wb_arb #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_p_valid,
    input  logic [ADDR_W-1:0] i_p_reg,
    input  logic [DATA_W-1:0] i_p_data,
    output logic              o_p_ready,
    input  logic              i_s_valid,
    input  logic [ADDR_W-1:0] i_s_reg,
    input  logic [DATA_W-1:0] i_s_data,
    output logic              o_s_ready,
    output logic              o_wrSig,
    output logic [ADDR_W-1:0] o_wrReg,
    output logic [DATA_W-1:0] o_wrData,
    output logic [1:0]        o_s_count
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    // FIFO storage; contents are only meaningful below the occupancy count
    logic [ADDR_W-1:0] fifo_reg  [2];
    logic [DATA_W-1:0] fifo_data [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        s_count;
    logic [3:0]        starve_cnt;

    logic              fifo_empty;
    logic              force_s;
    logic              p_fire;
    logic              s_fire;
    logic              grant_p;
    logic              grant_f;
    logic              enq;

    logic [1:0]        s_count_next;
    logic [3:0]        starve_next;
    logic              wr_sig_next;
    logic [ADDR_W-1:0] wr_reg_next;
    logic [DATA_W-1:0] wr_data_next;

    assign fifo_empty = (s_count == 2'd0);
    assign force_s    = (starve_cnt == STARVE_LIM) && !fifo_empty;

    assign o_p_ready  = !force_s && !i_reset;
    assign o_s_ready  = (s_count != 2'd2) && !i_reset;
    assign o_s_count  = s_count;

    assign p_fire     = i_p_valid && o_p_ready;
    assign s_fire     = i_s_valid && o_s_ready;

    // Writes to x0 complete their handshake but never reach the port or the FIFO
    assign grant_p    = p_fire && (i_p_reg != '0);
    assign grant_f    = !grant_p && !fifo_empty;
    assign enq        = s_fire && (i_s_reg != '0);

    always_comb begin
        s_count_next = s_count;
        unique case ({enq, grant_f})
            2'b10:   s_count_next = s_count + 2'd1;
            2'b01:   s_count_next = s_count - 2'd1;
            default: s_count_next = s_count;
        endcase
    end

    always_comb begin
        starve_next = starve_cnt;
        if (grant_f || fifo_empty) begin
            starve_next = 4'd0;
        end else if (grant_p && (starve_cnt != STARVE_LIM)) begin
            starve_next = starve_cnt + 4'd1;
        end
    end

    // With no grant the address/data hold, so only the enable toggles
    always_comb begin
        wr_sig_next  = 1'b0;
        wr_reg_next  = o_wrReg;
        wr_data_next = o_wrData;
        if (grant_p) begin
            wr_sig_next  = 1'b1;
            wr_reg_next  = i_p_reg;
            wr_data_next = i_p_data;
        end else if (grant_f) begin
            wr_sig_next  = 1'b1;
            wr_reg_next  = fifo_reg[rd_ptr];
            wr_data_next = fifo_data[rd_ptr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (enq) begin
            fifo_reg[wr_ptr]  <= i_s_reg;
            fifo_data[wr_ptr] <= i_s_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            s_count    <= 2'd0;
            starve_cnt <= 4'd0;
            o_wrSig    <= 1'b0;
            o_wrReg    <= '0;
            o_wrData   <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= !wr_ptr;
            end
            if (grant_f) begin
                rd_ptr <= !rd_ptr;
            end
            s_count    <= s_count_next;
            starve_cnt <= starve_next;
            o_wrSig    <= wr_sig_next;
            o_wrReg    <= wr_reg_next;
            o_wrData   <= wr_data_next;
        end
    end

endmodule

// File: tb/tb_id_wb_arb.sv
// Directed bench for id_wb_arb: primary path, secondary burst, starvation forcing,
// x0 filtering, asynchronous reset and simultaneous enqueue/dequeue.
module tb_id_wb_arb;

    logic        clk;
    logic        rst;
    logic        p_valid;
    logic [4:0]  p_reg;
    logic [31:0] p_data;
    logic        p_ready;
    logic        s_valid;
    logic [4:0]  s_reg;
    logic [31:0] s_data;
    logic        s_ready;
    logic        wr_sig;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [1:0]  s_count;

    int errors = 0;
    int checks = 0;

    id_wb_arb #(
        .DATA_W(32),
        .ADDR_W(5),
        .STARVE_MAX(4)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_p_valid(p_valid),
        .i_p_reg  (p_reg),
        .i_p_data (p_data),
        .o_p_ready(p_ready),
        .i_s_valid(s_valid),
        .i_s_reg  (s_reg),
        .i_s_data (s_data),
        .o_s_ready(s_ready),
        .o_wrSig  (wr_sig),
        .o_wrReg  (wr_reg),
        .o_wrData (wr_data),
        .o_s_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic sig, input logic [4:0] r, input logic [31:0] d);
        chk({tag, ".sig"}, 32'(wr_sig), 32'(sig));
        chk({tag, ".reg"}, 32'(wr_reg), 32'(r));
        chk({tag, ".data"}, wr_data, d);
        $display("t=%0t %s wrSig=%0d wrReg=%0d wrData=0x%0h s_count=%0d p_ready=%0d s_ready=%0d",
                 $time, tag, wr_sig, wr_reg, wr_data, s_count, p_ready, s_ready);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; p_valid = 1'b0; p_reg = '0; p_data = '0;
        s_valid = 1'b0; s_reg = '0; s_data = '0;

        // Reset state
        tick();
        chk_wr("reset", 1'b0, 5'd0, 32'h0);
        chk("reset.count", 32'(s_count), 32'd0);
        chk("reset.p_ready", 32'(p_ready), 32'd0);
        chk("reset.s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("release.p_ready", 32'(p_ready), 32'd1);
        chk("release.s_ready", 32'(s_ready), 32'd1);

        // Primary only
        p_valid = 1'b1; p_reg = 5'd5; p_data = 32'hDEADBEEF;
        tick();
        chk_wr("prim.wr", 1'b1, 5'd5, 32'hDEADBEEF);
        p_valid = 1'b0;
        tick();
        chk_wr("prim.idle", 1'b0, 5'd5, 32'hDEADBEEF);

        // Secondary burst: regs 1,2,3 on consecutive cycles
        s_valid = 1'b1; s_reg = 5'd1; s_data = 32'h11;
        tick();
        chk_wr("sburst.enq1", 1'b0, 5'd5, 32'hDEADBEEF);
        chk("sburst.count1", 32'(s_count), 32'd1);
        chk("sburst.ready1", 32'(s_ready), 32'd1);
        s_reg = 5'd2; s_data = 32'h22;
        tick();
        chk_wr("sburst.wr1", 1'b1, 5'd1, 32'h11);
        chk("sburst.count2", 32'(s_count), 32'd1);
        s_reg = 5'd3; s_data = 32'h33;
        tick();
        chk_wr("sburst.wr2", 1'b1, 5'd2, 32'h22);
        chk("sburst.count3", 32'(s_count), 32'd1);
        s_valid = 1'b0;
        tick();
        chk_wr("sburst.wr3", 1'b1, 5'd3, 32'h33);
        chk("sburst.count4", 32'(s_count), 32'd0);
        tick();
        chk("sburst.idle", 32'(wr_sig), 32'd0);

        // FIFO full and starvation forcing
        p_valid = 1'b1; p_reg = 5'd7; p_data = 32'h70;
        s_valid = 1'b1; s_reg = 5'd8; s_data = 32'h80;
        tick();
        chk_wr("starve.e1", 1'b1, 5'd7, 32'h70);
        chk("starve.e1.count", 32'(s_count), 32'd1);
        s_reg = 5'd9; s_data = 32'h90;
        tick();
        chk_wr("starve.e2", 1'b1, 5'd7, 32'h70);
        chk("starve.e2.count", 32'(s_count), 32'd2);
        chk("starve.e2.s_ready", 32'(s_ready), 32'd0);
        s_reg = 5'd10; s_data = 32'hA0;
        for (int i = 3; i <= 4; i++) begin
            tick();
            chk_wr("starve.pgrant", 1'b1, 5'd7, 32'h70);
            chk("starve.p_ready", 32'(p_ready), 32'd1);
            chk("starve.s_ready_full", 32'(s_ready), 32'd0);
        end
        tick();
        chk_wr("starve.e5", 1'b1, 5'd7, 32'h70);
        chk("starve.forced", 32'(p_ready), 32'd0);
        tick();
        chk_wr("starve.reg8", 1'b1, 5'd8, 32'h80);
        chk("starve.reg8.count", 32'(s_count), 32'd1);
        chk("starve.reg8.p_ready", 32'(p_ready), 32'd1);
        chk("starve.reg8.s_ready", 32'(s_ready), 32'd1);
        tick();
        chk_wr("starve.e7", 1'b1, 5'd7, 32'h70);
        chk("starve.e7.count", 32'(s_count), 32'd2);
        s_valid = 1'b0;
        for (int i = 8; i <= 9; i++) begin
            tick();
            chk_wr("starve.pgrant2", 1'b1, 5'd7, 32'h70);
            chk("starve.p_ready2", 32'(p_ready), 32'd1);
        end
        tick();
        chk_wr("starve.e10", 1'b1, 5'd7, 32'h70);
        chk("starve.forced2", 32'(p_ready), 32'd0);
        tick();
        chk_wr("starve.reg9", 1'b1, 5'd9, 32'h90);
        chk("starve.reg9.count", 32'(s_count), 32'd1);
        p_valid = 1'b0;
        tick();
        chk_wr("starve.reg10", 1'b1, 5'd10, 32'hA0);
        chk("starve.reg10.count", 32'(s_count), 32'd0);
        tick();
        chk("starve.idle", 32'(wr_sig), 32'd0);

        // x0 filtering
        s_valid = 1'b1; s_reg = 5'd4; s_data = 32'h44;
        tick();
        chk("x0.enq.count", 32'(s_count), 32'd1);
        s_valid = 1'b0;
        p_valid = 1'b1; p_reg = 5'd0; p_data = 32'h55;
        #1;
        chk("x0.p_ready", 32'(p_ready), 32'd1);
        tick();
        chk_wr("x0.headwr", 1'b1, 5'd4, 32'h44);
        chk("x0.count0", 32'(s_count), 32'd0);
        p_valid = 1'b0;
        s_valid = 1'b1; s_reg = 5'd0; s_data = 32'h66;
        #1;
        chk("x0.s_ready", 32'(s_ready), 32'd1);
        tick();
        chk_wr("x0.sec", 1'b0, 5'd4, 32'h44);
        chk("x0.sec.count", 32'(s_count), 32'd0);
        s_valid = 1'b0;
        tick();
        chk("x0.sec.nowrite", 32'(wr_sig), 32'd0);

        // Reset mid-operation with a full FIFO and a pending write
        p_valid = 1'b1; p_reg = 5'd12; p_data = 32'hC0;
        s_valid = 1'b1; s_reg = 5'd13; s_data = 32'hD0;
        tick();
        s_reg = 5'd14; s_data = 32'hE0;
        tick();
        chk_wr("rst.pre", 1'b1, 5'd12, 32'hC0);
        chk("rst.pre.count", 32'(s_count), 32'd2);
        p_valid = 1'b0; s_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_wr("rst.async", 1'b0, 5'd0, 32'h0);
        chk("rst.async.count", 32'(s_count), 32'd0);
        chk("rst.async.p_ready", 32'(p_ready), 32'd0);
        chk("rst.async.s_ready", 32'(s_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst.rel.p_ready", 32'(p_ready), 32'd1);
        chk("rst.rel.s_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_wr("rst.nostale", 1'b0, 5'd0, 32'h0);
            chk("rst.nostale.count", 32'(s_count), 32'd0);
        end

        // Simultaneous enqueue and dequeue
        s_valid = 1'b1; s_reg = 5'd17; s_data = 32'h170;
        tick();
        chk("simul.count1", 32'(s_count), 32'd1);
        s_reg = 5'd18; s_data = 32'h180;
        tick();
        chk_wr("simul.wr17", 1'b1, 5'd17, 32'h170);
        chk("simul.count_hold", 32'(s_count), 32'd1);
        s_valid = 1'b0;
        tick();
        chk_wr("simul.wr18", 1'b1, 5'd18, 32'h180);
        chk("simul.count0", 32'(s_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
